qsn_shift_pipe: RTL and testbench

QSN_SHIFT_PIPE -- requirements
Module: qsn_shift_pipe

---
 rtl/qsn_shift_pipe.sv | 171 +++++++++++++++++
 tb/tb_qsn_shift_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsn_shift_pipe.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// qsn_shift_pipe
// Cyclic shifter for a vector of Z messages of QW bits each. It is built on
// the QSN left/right/merge structure and pipelined in two stages.
// Stage 1 captures three things: the left-shifted vector, the right-shifted
// vector and the per-message merge-select mask. Stage 2 captures the merged
// result. Valid/ready handshakes are used on both the input and the output.
//
// Parameters
//   Z   messages per vector (2..512)
//   QW  bits per message
//   SW  shift-factor width; 2**SW must be >= Z
//
// Ports
//   sys_clk    clock; all state changes on its rising edge
//   rstn       asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   block accepts an input beat this cycle (combinational)
//   msg_in     input vector; message k is bits [k*QW +: QW]
//   shift_in   cyclic shift factor s
//   dir_in     0 = shift down (out[k] = in[(k+s) mod Z]), 1 = shift up
//   out_valid  output beat present
//   out_ready  downstream accepts the output beat
//   msg_out    shifted vector, same packing as msg_in
//   err_out    the beat on msg_out had an out-of-range shift (s >= Z)
//   err_cnt    saturating count of accepted beats with out-of-range shift
// ---------------------------------------------------------------------------
module qsn_shift_pipe #(
   parameter int Z  = 85,
   parameter int QW = 4,
   parameter int SW = 7
) (
   input  logic              sys_clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [Z*QW-1:0]   msg_in,
   input  logic [SW-1:0]     shift_in,
   input  logic              dir_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [Z*QW-1:0]   msg_out,
   output logic              err_out,
   output logic [15:0]       err_cnt
);

   localparam int VW = Z * QW;

   // ---------------- shift-factor decode ----------------
   logic [31:0]   w_shift;
   logic          w_err;
   logic [31:0]   w_s_eff;    // effective down-shift, 0..Z-1
   logic [31:0]   w_r_amt;    // right-shifter amount, (Z - s_eff) mod Z

   assign w_shift = 32'(shift_in);
   assign w_err   = (w_shift >= 32'(Z));

   always_comb begin
      w_s_eff = 32'd0;
      if (w_err || (w_shift == 32'd0)) begin
         w_s_eff = 32'd0;
      end else if (dir_in) begin
         // An up shift by s is the same as a down shift by Z-s.
         w_s_eff = 32'(Z) - w_shift;
      end else begin
         w_s_eff = w_shift;
      end
   end

   // When s_eff is 0, the right shifter passes the vector through unshifted.
   // Message Z-1 is always taken from the right-shifted source, so it then
   // still receives its own value.
   assign w_r_amt = (w_s_eff == 32'd0) ? 32'd0 : (32'(Z) - w_s_eff);

   // ---------------- left / right shifters ----------------
   // Left shift moves message k+s down to slot k; the top s slots are
   // zero-filled. Right shift moves message k-r up to slot k; the bottom r
   // slots are zero-filled. The mask picks the valid half of each.
   logic [VW-1:0] w_left;
   logic [VW-1:0] w_right;
   logic [Z-2:0]  w_mask;

   assign w_left  = msg_in >> (w_s_eff * 32'(QW));
   assign w_right = msg_in << (w_r_amt * 32'(QW));

   generate
      for (genvar gi = 0; gi < Z - 1; gi++) begin : g_mask
         // 1 selects the left-shifted source.
         assign w_mask[gi] = (32'(gi) < (32'(Z) - w_s_eff));
      end
   endgenerate

   // ---------------- pipeline control ----------------
   logic r_v1;
   logic r_v2;
   logic w_e1;
   logic w_e2;

   assign w_e2     = !r_v2 | out_ready;
   assign w_e1     = !r_v1 | w_e2;
   assign in_ready = w_e1;
   assign out_valid = r_v2;

   // ---------------- stage 1 registers ----------------
   logic [VW-1:0] r_left1;
   logic [VW-1:0] r_right1;
   logic [Z-2:0]  r_mask1;
   logic          r_err1;

   // ---------------- merge ----------------
   logic [VW-1:0] w_merged;

   generate
      for (genvar gi = 0; gi < Z; gi++) begin : g_merge
         if (gi < Z - 1) begin : g_sel
            assign w_merged[gi*QW +: QW] = r_mask1[gi] ? r_left1[gi*QW +: QW]
                                                       : r_right1[gi*QW +: QW];
         end else begin : g_last
            assign w_merged[gi*QW +: QW] = r_right1[gi*QW +: QW];
         end
      end
   endgenerate

   // ---------------- stage 2 registers ----------------
   logic [VW-1:0] r_msg2;
   logic          r_err2;
   logic [15:0]   r_err_cnt;

   assign msg_out = r_msg2;
   assign err_out = r_err2;
   assign err_cnt = r_err_cnt;

   // Control state and error reporting; cleared by reset.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_err2    <= 1'b0;
         r_err_cnt <= 16'd0;
      end else begin
         if (w_e1) begin
            r_v1 <= in_valid;
         end
         if (w_e2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_err2 <= r_err1;
            end
         end
         if (in_valid && w_e1 && w_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   // Wide data registers. They do not need a reset because each stage is
   // qualified by its valid bit.
   always_ff @(posedge sys_clk) begin
      if (w_e1 && in_valid) begin
         r_left1  <= w_left;
         r_right1 <= w_right;
         r_mask1  <= w_mask;
         r_err1   <= w_err;
      end
      if (w_e2 && r_v1) begin
         r_msg2 <= w_merged;
      end
   end

endmodule

// File: tb/tb_qsn_shift_pipe.sv
`timescale 1ns / 1ps
module tb_qsn_shift_pipe;

   localparam int Z  = 85;
   localparam int QW = 4;
   localparam int SW = 7;
   localparam int VW = Z * QW;

   logic            sys_clk;
   logic            rstn;
   logic            in_valid;
   logic            in_ready;
   logic [VW-1:0]   msg_in;
   logic [SW-1:0]   shift_in;
   logic            dir_in;
   logic            out_valid;
   logic            out_ready;
   logic [VW-1:0]   msg_out;
   logic            err_out;
   logic [15:0]     err_cnt;

   int vectors    = 0;
   int miscompares = 0;

   qsn_shift_pipe #(.Z(Z), .QW(QW), .SW(SW)) dut (
      .sys_clk   (sys_clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .msg_in    (msg_in),
      .shift_in  (shift_in),
      .dir_in    (dir_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .msg_out   (msg_out),
      .err_out   (err_out),
      .err_cnt   (err_cnt)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Reference: out[k] = in[(k+s) mod Z] (down) or in[(k-s) mod Z] (up).
   // Any s >= Z passes the vector through unchanged.
   function automatic logic [VW-1:0] model(input logic [VW-1:0] v, input int s, input bit d);
      logic [VW-1:0] r;
      int src;
      r = v;
      if (s < Z) begin
         for (int k = 0; k < Z; k++) begin
            src = d ? ((k - s + Z) % Z) : ((k + s) % Z);
            r[k*QW +: QW] = v[src*QW +: QW];
         end
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] ramp_vec();
      logic [VW-1:0] r;
      for (int k = 0; k < Z; k++) r[k*QW +: QW] = QW'(k % 16);
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] r;
      logic [31:0] w;
      for (int k = 0; k < Z; k++) begin
         w = $urandom;
         r[k*QW +: QW] = w[QW-1:0];
      end
      return r;
   endfunction

   // Presents one beat with out_ready=1 and reports what was seen after the
   // first edge and after the second edge.
   task automatic send_one(input logic [VW-1:0] v, input int s, input bit d,
                           output bit rdy, output bit early_v, output bit ov,
                           output logic [VW-1:0] m, output bit e);
      logic [31:0] sv;
      sv        = 32'(s);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      msg_in    = v;
      shift_in  = sv[SW-1:0];
      dir_in    = d;
      #1;
      rdy = in_ready;
      @(posedge sys_clk); #1;
      in_valid = 1'b0;
      early_v  = out_valid;
      @(posedge sys_clk); #1;
      ov = out_valid;
      m  = msg_out;
      e  = err_out;
      $display("beat s=%0d dir=%0d -> out_valid=%0b err_out=%0b", s, d, ov, e);
   endtask

   task automatic test_reset();
      rstn      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      msg_in    = '0;
      shift_in  = '0;
      dir_in    = 1'b0;
      #12;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      vectors++; if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
      vectors++; if (err_out !== 1'b0) begin miscompares++; $display("FAIL reset_err_out got %0b want 0", err_out); end
      rstn = 1'b1;
      @(posedge sys_clk); #1;
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_down_shift();
      bit rdy, ev, ov, e;
      logic [VW-1:0] m;
      send_one(ramp_vec(), 1, 1'b0, rdy, ev, ov, m, e);
      vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL down_in_ready got %0b want 1", rdy); end
      vectors++; if (ev !== 1'b0) begin miscompares++; $display("FAIL down_latency_early got out_valid=%0b want 0", ev); end
      vectors++; if (ov !== 1'b1) begin miscompares++; $display("FAIL down_out_valid got %0b want 1", ov); end
      vectors++; if (m[0 +: 4] !== 4'd1) begin miscompares++; $display("FAIL down_msg0 got %0d want 1", m[0 +: 4]); end
      vectors++; if (m[84*4 +: 4] !== 4'd0) begin miscompares++; $display("FAIL down_msg84 got %0d want 0", m[84*4 +: 4]); end
      vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL down_err got %0b want 0", e); end
      vectors++; if (m !== model(ramp_vec(), 1, 1'b0)) begin miscompares++; $display("FAIL down_vector got %h want %h", m, model(ramp_vec(), 1, 1'b0)); end
   endtask

   task automatic test_up_shift();
      bit rdy, ev, ov, e;
      logic [VW-1:0] m;
      send_one(ramp_vec(), 3, 1'b1, rdy, ev, ov, m, e);
      vectors++; if (m[0 +: 4] !== 4'd2) begin miscompares++; $display("FAIL up_msg0 got %0d want 2", m[0 +: 4]); end
      vectors++; if (m[3*4 +: 4] !== 4'd0) begin miscompares++; $display("FAIL up_msg3 got %0d want 0", m[3*4 +: 4]); end
      vectors++; if (ov !== 1'b1 || e !== 1'b0) begin miscompares++; $display("FAIL up_flags got valid=%0b err=%0b want 1/0", ov, e); end
      vectors++; if (m !== model(ramp_vec(), 3, 1'b1)) begin miscompares++; $display("FAIL up_vector got %h want %h", m, model(ramp_vec(), 3, 1'b1)); end
   endtask

   task automatic test_zero_and_edge_shift();
      bit rdy, ev, ov, e;
      logic [VW-1:0] m;
      logic [VW-1:0] v;
      int s_tab[4] = '{0, 0, 84, 84};
      bit d_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         v = rand_vec();
         send_one(v, s_tab[i], d_tab[i], rdy, ev, ov, m, e);
         vectors++; if (m !== model(v, s_tab[i], d_tab[i]) || ov !== 1'b1 || e !== 1'b0) begin
            miscompares++; $display("FAIL edge_shift_%0d got %h err=%0b want %h err=0", i, m, e, model(v, s_tab[i], d_tab[i]));
         end
      end
   endtask

   task automatic test_errors();
      logic [VW-1:0] va, vb;
      va = rand_vec();
      vb = rand_vec();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      msg_in    = va;
      shift_in  = 7'd85;
      dir_in    = 1'b0;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL err_in_ready got %0b want 1", in_ready); end
      @(posedge sys_clk); #1;
      msg_in   = vb;
      shift_in = 7'd127;
      @(posedge sys_clk); #1;
      in_valid = 1'b0;
      $display("beat s=85 dir=0 -> out_valid=%0b err_out=%0b", out_valid, err_out);
      vectors++; if (out_valid !== 1'b1 || msg_out !== va || err_out !== 1'b1) begin
         miscompares++; $display("FAIL err_beat85 got valid=%0b err=%0b msg=%h want 1/1 %h", out_valid, err_out, msg_out, va);
      end
      @(posedge sys_clk); #1;
      $display("beat s=127 dir=0 -> out_valid=%0b err_out=%0b", out_valid, err_out);
      vectors++; if (out_valid !== 1'b1 || msg_out !== vb || err_out !== 1'b1) begin
         miscompares++; $display("FAIL err_beat127 got valid=%0b err=%0b msg=%h want 1/1 %h", out_valid, err_out, msg_out, vb);
      end
      vectors++; if (err_cnt !== 16'd2) begin miscompares++; $display("FAIL err_cnt got %0d want 2", err_cnt); end
      @(posedge sys_clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL err_drain got out_valid=%0b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [VW-1:0] vec [10];
      int s_v [10];
      bit d_v [10];
      int sent = 0;
      int rcvd = 0;
      bit prev_stall = 1'b0;
      logic [VW-1:0] prev_msg;
      logic [VW-1:0] exp_m;
      logic [31:0] sv;
      prev_msg = '0;
      for (int i = 0; i < 10; i++) begin
         vec[i] = rand_vec();
         s_v[i] = i * 9;
         d_v[i] = i[0];
      end
      for (int c = 0; c < 200 && rcvd < 10; c++) begin
         out_ready = (c % 2 == 0);
         if (sent < 10) begin
            sv       = 32'(s_v[sent]);
            in_valid = 1'b1;
            msg_in   = vec[sent];
            shift_in = sv[SW-1:0];
            dir_in   = d_v[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (prev_stall) begin
            vectors++; if (out_valid !== 1'b1 || msg_out !== prev_msg) begin
               miscompares++; $display("FAIL stall_hold got valid=%0b msg=%h want 1 %h", out_valid, msg_out, prev_msg);
            end
         end
         if (out_valid && out_ready) begin
            exp_m = model(vec[rcvd], s_v[rcvd], d_v[rcvd]);
            $display("stream beat %0d s=%0d dir=%0d delivered", rcvd, s_v[rcvd], d_v[rcvd]);
            vectors++; if (msg_out !== exp_m || err_out !== 1'b0) begin
               miscompares++; $display("FAIL stream_beat_%0d got %h err=%0b want %h err=0", rcvd, msg_out, err_out, exp_m);
            end
            rcvd++;
         end
         prev_stall = out_valid && !out_ready;
         prev_msg   = msg_out;
         if (in_valid && in_ready) sent++;
         @(posedge sys_clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      vectors++; if (rcvd !== 10 || sent !== 10) begin miscompares++; $display("FAIL stream_count got sent=%0d rcvd=%0d want 10/10", sent, rcvd); end
      @(posedge sys_clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_extra got out_valid=%0b want 0", out_valid); end
   endtask

   task automatic test_capacity();
      logic [VW-1:0] b [3];
      int s_b [3] = '{5, 10, 0};
      bit d_b [3] = '{1'b0, 1'b1, 1'b0};
      int acc = 0;
      logic [31:0] sv;
      for (int i = 0; i < 3; i++) b[i] = rand_vec();
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         sv       = 32'(s_b[acc]);
         in_valid = 1'b1;
         msg_in   = b[acc];
         shift_in = sv[SW-1:0];
         dir_in   = d_b[acc];
         #1;
         if (in_valid && in_ready) acc++;
         @(posedge sys_clk); #1;
      end
      vectors++; if (acc !== 2) begin miscompares++; $display("FAIL cap_accepted got %0d want 2", acc); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL cap_full_ready got %0b want 0", in_ready); end
      // One cycle of out_ready: one beat leaves while the third enters.
      sv        = 32'(s_b[2]);
      msg_in    = b[2];
      shift_in  = sv[SW-1:0];
      dir_in    = d_b[2];
      out_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL cap_coincident_ready got %0b want 1", in_ready); end
      vectors++; if (out_valid !== 1'b1 || msg_out !== model(b[0], s_b[0], d_b[0])) begin
         miscompares++; $display("FAIL cap_beat0 got valid=%0b msg=%h want 1 %h", out_valid, msg_out, model(b[0], s_b[0], d_b[0]));
      end
      $display("capacity beat 0 delivered while beat 2 accepted");
      @(posedge sys_clk); #1;
      out_ready = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || msg_out !== model(b[1], s_b[1], d_b[1])) begin
         miscompares++; $display("FAIL cap_beat1 got valid=%0b ready=%0b msg=%h want 1/0 %h", out_valid, in_ready, msg_out, model(b[1], s_b[1], d_b[1]));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge sys_clk); #1;
      vectors++; if (out_valid !== 1'b1 || msg_out !== model(b[2], s_b[2], d_b[2])) begin
         miscompares++; $display("FAIL cap_beat2 got valid=%0b msg=%h want 1 %h", out_valid, msg_out, model(b[2], s_b[2], d_b[2]));
      end
      @(posedge sys_clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL cap_drain got out_valid=%0b want 0", out_valid); end
   endtask

   task automatic test_async_reset();
      bit rdy, ev, ov, e;
      logic [VW-1:0] m;
      logic [VW-1:0] v;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      msg_in    = rand_vec();
      shift_in  = 7'd100;
      dir_in    = 1'b0;
      @(posedge sys_clk); #1;
      msg_in   = rand_vec();
      shift_in = 7'd2;
      @(posedge sys_clk); #1;
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1 || err_out !== 1'b1 || err_cnt !== 16'd3) begin
         miscompares++; $display("FAIL inflight got valid=%0b err=%0b cnt=%0d want 1/1/3", out_valid, err_out, err_cnt);
      end
      #2;
      rstn = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0 || err_cnt !== 16'd0 || err_out !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++; $display("FAIL async_clear got valid=%0b cnt=%0d err=%0b ready=%0b want 0/0/0/1", out_valid, err_cnt, err_out, in_ready);
      end
      rstn      = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge sys_clk); #1;
         vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stale_beat cycle %0d got out_valid=%0b want 0", c, out_valid); end
      end
      v = rand_vec();
      send_one(v, 40, 1'b1, rdy, ev, ov, m, e);
      vectors++; if (ov !== 1'b1 || m !== model(v, 40, 1'b1) || e !== 1'b0) begin
         miscompares++; $display("FAIL post_async_beat got valid=%0b msg=%h want 1 %h", ov, m, model(v, 40, 1'b1));
      end
   endtask

   initial begin
      test_reset();
      test_down_shift();
      test_up_shift();
      test_zero_and_edge_shift();
      test_errors();
      test_back_to_back();
      test_capacity();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
